// File: rtl/dmem_mmio_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_mmio_responder
// Brief    : Data-memory responder: word RAM plus MMIO page (cycle counter,
//            timer compare/IRQ, console TX FIFO). Reads are combinational.
// Revision : 1.0
// ============================================================================
module dmem_mmio_responder #(
  parameter int RAM_WORDS  = 64,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        timer_irq
);

  localparam int c_aw = $clog2(RAM_WORDS);
  localparam int c_pw = $clog2(FIFO_DEPTH);
  localparam int c_cw = c_pw + 1;
  localparam logic [c_cw-1:0] c_full_cnt = c_cw'(FIFO_DEPTH);

  localparam logic [2:0] c_reg_cycle   = 3'd0;
  localparam logic [2:0] c_reg_txdata  = 3'd1;
  localparam logic [2:0] c_reg_status  = 3'd2;
  localparam logic [2:0] c_reg_dropcnt = 3'd3;
  localparam logic [2:0] c_reg_timecmp = 3'd4;

  logic [31:0]     r_ram [RAM_WORDS];
  logic [7:0]      r_fifo [FIFO_DEPTH];
  logic [c_pw-1:0] r_wptr;
  logic [c_pw-1:0] r_rptr;
  logic [c_cw-1:0] r_count;
  logic [31:0]     r_cycle;
  logic [31:0]     r_timecmp;
  logic [15:0]     r_dropcnt;
  logic            r_irq;

  logic            w_mmio;
  logic [2:0]      w_reg;
  logic [c_aw-1:0] w_ram_idx;
  logic            w_ram_we;
  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic            w_push_ok;
  logic            w_drop;
  logic            w_unused_bits;

  assign w_mmio    = addr[31];
  assign w_reg     = addr[4:2];
  assign w_ram_idx = addr[c_aw+1:2];
  assign w_ram_we  = memwrite & ~w_mmio;

  assign w_full    = (r_count == c_full_cnt);
  assign w_empty   = (r_count == '0);
  assign w_push    = memwrite & w_mmio & (w_reg == c_reg_txdata);
  assign w_pop     = ~w_empty & tx_ready;
  // A pop in the same cycle frees the slot a full-FIFO push needs.
  assign w_push_ok = w_push & (~w_full | w_pop);
  assign w_drop    = w_push & w_full & ~w_pop;

  assign tx_valid  = ~w_empty;
  assign tx_data   = w_empty ? 8'd0 : r_fifo[r_rptr];
  assign timer_irq = r_irq;

  assign w_unused_bits = ^{addr[30:c_aw+2], addr[1:0]};

  always_comb begin
    readdata = 32'd0;
    if (!w_mmio) begin
      readdata = r_ram[w_ram_idx];
    end else begin
      case (w_reg)
        c_reg_cycle:   readdata = r_cycle;
        c_reg_status:  readdata = {19'd0, 5'(r_count), 6'd0, w_empty, w_full};
        c_reg_dropcnt: readdata = {16'd0, r_dropcnt};
        c_reg_timecmp: readdata = r_timecmp;
        default:       readdata = 32'd0;
      endcase
    end
  end

  // RAM and FIFO storage carry no reset; only pointers and counts do.
  always_ff @(posedge clk) begin
    if (!reset && w_ram_we) begin
      r_ram[w_ram_idx] <= writedata;
    end
    if (!reset && w_push_ok) begin
      r_fifo[r_wptr] <= writedata[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_cycle   <= 32'd0;
      r_timecmp <= 32'hFFFF_FFFF;
      r_dropcnt <= 16'd0;
      r_irq     <= 1'b0;
    end else begin
      r_cycle <= r_cycle + 32'd1;
      r_irq   <= (r_cycle >= r_timecmp);
      if (w_push_ok) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (memwrite && w_mmio && (w_reg == c_reg_timecmp)) begin
        r_timecmp <= writedata;
      end
      if (memwrite && w_mmio && (w_reg == c_reg_dropcnt)) begin
        r_dropcnt <= 16'd0;
      end else if (w_drop && (r_dropcnt != 16'hFFFF)) begin
        r_dropcnt <= r_dropcnt + 16'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_mmio_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_mmio_responder
// Brief    : Directed self-checking bench for dmem_mmio_responder.
// Revision : 1.0
// ============================================================================
module tb_dmem_mmio_responder;

  logic        clk;
  logic        reset;
  logic        memwrite;
  logic [31:0] addr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        timer_irq;

  int n_vec;
  int n_err;

  localparam logic [31:0] A_CYCLE   = 32'h8000_0000;
  localparam logic [31:0] A_TXDATA  = 32'h8000_0004;
  localparam logic [31:0] A_STATUS  = 32'h8000_0008;
  localparam logic [31:0] A_DROPCNT = 32'h8000_000C;
  localparam logic [31:0] A_TIMECMP = 32'h8000_0010;

  dmem_mmio_responder #(.RAM_WORDS(64), .FIFO_DEPTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .memwrite  (memwrite),
    .addr      (addr),
    .writedata (writedata),
    .readdata  (readdata),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .timer_irq (timer_irq)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setaddr(input logic [31:0] a);
    addr = a;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; memwrite = 1'b0; tx_ready = 1'b0; addr = 32'd0; writedata = 32'd0;
    tick(); tick(); tick();
    n_vec++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL rst_tx_valid: got %b expected 0", tx_valid); end
    n_vec++; if (tx_data !== 8'h00) begin n_err++; $display("FAIL rst_tx_data: got %h expected 00", tx_data); end
    n_vec++; if (timer_irq !== 1'b0) begin n_err++; $display("FAIL rst_irq: got %b expected 0", timer_irq); end
    setaddr(A_STATUS);
    n_vec++; if (readdata !== 32'h0000_0002) begin n_err++; $display("FAIL rst_status: got %h expected 00000002", readdata); end
    setaddr(A_DROPCNT);
    n_vec++; if (readdata !== 32'h0) begin n_err++; $display("FAIL rst_dropcnt: got %h expected 0", readdata); end
    setaddr(A_TIMECMP);
    n_vec++; if (readdata !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL rst_timecmp: got %h expected ffffffff", readdata); end
    setaddr(A_CYCLE);
    reset = 1'b0;
    #1;
    n_vec++; if (readdata !== 32'd0) begin n_err++; $display("FAIL cycle_first: got %0d expected 0", readdata); end
    for (int i = 0; i < 5; i++) tick();
    n_vec++; if (readdata !== 32'd5) begin n_err++; $display("FAIL cycle_5: got %0d expected 5", readdata); end
    setaddr(32'h8000_0100);
    n_vec++; if (readdata !== 32'd5) begin n_err++; $display("FAIL cycle_alias: got %0d expected 5", readdata); end
  endtask

  task automatic test_ram();
    memwrite = 1'b1; addr = 32'h0000_0010; writedata = 32'h1111_1111;
    tick();
    writedata = 32'hDEAD_BEEF;
    #1;
    n_vec++; if (readdata !== 32'h1111_1111) begin n_err++; $display("FAIL ram_same_cycle: got %h expected 11111111", readdata); end
    tick();
    memwrite = 1'b0;
    #1;
    n_vec++; if (readdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL ram_readback: got %h expected deadbeef", readdata); end
    setaddr(32'h0000_0110);
    n_vec++; if (readdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL ram_alias: got %h expected deadbeef", readdata); end
    setaddr(32'h0000_0013);
    n_vec++; if (readdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL ram_lowbits: got %h expected deadbeef", readdata); end
    memwrite = 1'b1; addr = 32'h0000_00FC; writedata = 32'h1234_5678;
    tick();
    memwrite = 1'b0;
    setaddr(32'h0000_00FC);
    n_vec++; if (readdata !== 32'h1234_5678) begin n_err++; $display("FAIL ram_top: got %h expected 12345678", readdata); end
    setaddr(32'h0000_0010);
    n_vec++; if (readdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL ram_keep: got %h expected deadbeef", readdata); end
  endtask

  task automatic test_cycle_wrap();
    memwrite = 1'b0;
    tick();
    force dut.r_cycle = 32'hFFFF_FFFF;
    setaddr(A_CYCLE);
    n_vec++; if (readdata !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL cycle_preload: got %h expected ffffffff", readdata); end
    release dut.r_cycle;
    tick();
    n_vec++; if (readdata !== 32'd0) begin n_err++; $display("FAIL cycle_wrap: got %h expected 0", readdata); end
    memwrite = 1'b1; writedata = 32'h0000_1234;
    tick();
    memwrite = 1'b0;
    #1;
    n_vec++; if (readdata !== 32'd1) begin n_err++; $display("FAIL cycle_ro: got %h expected 1", readdata); end
  endtask

  task automatic test_fifo_fill_drop();
    tx_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      memwrite = 1'b1; addr = A_TXDATA; writedata = 32'hABCD_0041 + 32'(i);
      tick();
    end
    memwrite = 1'b0;
    setaddr(A_STATUS);
    n_vec++; if (readdata !== 32'h0000_0801) begin n_err++; $display("FAIL fill_status: got %h expected 00000801", readdata); end
    setaddr(A_DROPCNT);
    n_vec++; if (readdata !== 32'd1) begin n_err++; $display("FAIL fill_dropcnt: got %h expected 1", readdata); end
    setaddr(A_TXDATA);
    n_vec++; if (readdata !== 32'd0) begin n_err++; $display("FAIL txdata_read: got %h expected 0", readdata); end
    n_vec++; if (tx_valid !== 1'b1 || tx_data !== 8'h41) begin n_err++; $display("FAIL fill_head: got %b/%h expected 1/41", tx_valid, tx_data); end
  endtask

  task automatic test_push_pop_full();
    logic [7:0] exp_q [8];
    exp_q = '{8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h55};
    memwrite = 1'b1; addr = A_TXDATA; writedata = 32'h0000_0055; tx_ready = 1'b1;
    tick();
    memwrite = 1'b0; tx_ready = 1'b0;
    setaddr(A_STATUS);
    n_vec++; if (readdata !== 32'h0000_0801) begin n_err++; $display("FAIL pp_full_status: got %h expected 00000801", readdata); end
    setaddr(A_DROPCNT);
    n_vec++; if (readdata !== 32'd1) begin n_err++; $display("FAIL pp_full_dropcnt: got %h expected 1", readdata); end
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n_vec++;
      if (tx_valid !== 1'b1 || tx_data !== exp_q[i]) begin
        n_err++; $display("FAIL drain[%0d]: got %b/%h expected 1/%h", i, tx_valid, tx_data, exp_q[i]);
      end
      tick();
    end
    n_vec++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin n_err++; $display("FAIL drained: got %b/%h expected 0/00", tx_valid, tx_data); end
    setaddr(A_STATUS);
    n_vec++; if (readdata !== 32'h0000_0002) begin n_err++; $display("FAIL drained_status: got %h expected 00000002", readdata); end
    memwrite = 1'b1; addr = A_TXDATA; writedata = 32'h0000_0077;
    tick();
    memwrite = 1'b0; tx_ready = 1'b0;
    setaddr(A_STATUS);
    n_vec++; if (readdata !== 32'h0000_0100 || tx_data !== 8'h77) begin n_err++; $display("FAIL push_empty_ready: got %h/%h expected 00000100/77", readdata, tx_data); end
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    n_vec++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL pop_last: got %b expected 0", tx_valid); end
  endtask

  task automatic test_regs_misc();
    memwrite = 1'b1; addr = A_DROPCNT; writedata = 32'h0;
    #1;
    n_vec++; if (readdata !== 32'd1) begin n_err++; $display("FAIL dropcnt_preclear: got %h expected 1", readdata); end
    tick();
    memwrite = 1'b0;
    #1;
    n_vec++; if (readdata !== 32'd0) begin n_err++; $display("FAIL dropcnt_clear: got %h expected 0", readdata); end
    memwrite = 1'b1; addr = 32'h8000_0014; writedata = 32'hFFFF_FFFF;
    tick();
    memwrite = 1'b0;
    #1;
    n_vec++; if (readdata !== 32'd0) begin n_err++; $display("FAIL mmio5: got %h expected 0", readdata); end
    setaddr(32'h8000_001C);
    n_vec++; if (readdata !== 32'd0) begin n_err++; $display("FAIL mmio7: got %h expected 0", readdata); end
  endtask

  task automatic test_timer();
    memwrite = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    setaddr(A_CYCLE);
    n_vec++; if (readdata !== 32'd10) begin n_err++; $display("FAIL timer_cycle10: got %0d expected 10", readdata); end
    memwrite = 1'b1; addr = A_TIMECMP; writedata = 32'd20;
    tick();
    memwrite = 1'b0;
    #1;
    n_vec++; if (readdata !== 32'd20) begin n_err++; $display("FAIL timecmp_rd: got %0d expected 20", readdata); end
    for (int c = 11; c <= 24; c++) begin
      n_vec++;
      if (timer_irq !== (c >= 21)) begin n_err++; $display("FAIL irq_at_%0d: got %b expected %b", c, timer_irq, (c >= 21)); end
      if (c < 24) tick();
    end
    memwrite = 1'b1; addr = A_TIMECMP; writedata = 32'hFFFF_FFFF;
    tick();
    memwrite = 1'b0;
    n_vec++; if (timer_irq !== 1'b1) begin n_err++; $display("FAIL irq_hold: got %b expected 1", timer_irq); end
    tick();
    n_vec++; if (timer_irq !== 1'b0) begin n_err++; $display("FAIL irq_drop: got %b expected 0", timer_irq); end
  endtask

  task automatic test_reset_mid_drain();
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      memwrite = 1'b1; addr = A_TXDATA; writedata = 32'h0000_00AA + 32'(i * 17);
      tick();
    end
    memwrite = 1'b0; tx_ready = 1'b1;
    #1;
    n_vec++; if (tx_data !== 8'hAA) begin n_err++; $display("FAIL mid_head0: got %h expected aa", tx_data); end
    tick();
    n_vec++; if (tx_data !== 8'hBB) begin n_err++; $display("FAIL mid_head1: got %h expected bb", tx_data); end
    reset = 1'b1; memwrite = 1'b1; addr = 32'h0000_0010; writedata = 32'hCAFE_F00D;
    tick();
    reset = 1'b0; memwrite = 1'b0; tx_ready = 1'b0;
    #1;
    n_vec++; if (readdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL rst_write_discard: got %h expected deadbeef", readdata); end
    n_vec++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin n_err++; $display("FAIL mid_rst_tx: got %b/%h expected 0/00", tx_valid, tx_data); end
    setaddr(A_STATUS);
    n_vec++; if (readdata !== 32'h0000_0002) begin n_err++; $display("FAIL mid_rst_status: got %h expected 00000002", readdata); end
    setaddr(A_DROPCNT);
    n_vec++; if (readdata !== 32'd0) begin n_err++; $display("FAIL mid_rst_dropcnt: got %h expected 0", readdata); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1; memwrite = 1'b0; tx_ready = 1'b0; addr = 32'd0; writedata = 32'd0;
    test_reset();
    test_ram();
    test_cycle_wrap();
    test_fifo_fill_drop();
    test_push_pop_full();
    test_regs_misc();
    test_timer();
    test_reset_mid_drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/dmem_mmio_responder.md
Name: dmem_mmio_responder

Overview:
- Responder for the core's data-memory port: memwrite, address, writedata in; readdata out.
- Decodes each access to either word-addressed data RAM or a small MMIO page.
- MMIO page holds a free-running cycle counter, a timer compare with interrupt, and a byte-wide console TX FIFO drained over a valid/ready port.
- Sits beside the core at SoC top level. Reads are combinational, so the M-stage load completes in the same cycle; no stalls are ever requested.

Parameters:
- RAM_WORDS, 64, data RAM depth in 32-bit words (power of 2, at least 2).
- FIFO_DEPTH, 8, TX FIFO entries (power of 2, 2..16).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- memwrite  in  1  write strobe from core M stage.
- addr  in  32  byte address (core ALU result, M stage).
- writedata  in  32  store data.
- readdata  out  32  load data, combinational from addr and current state.
- tx_valid  out  1  FIFO non-empty.
- tx_data  out  8  FIFO head byte.
- tx_ready  in  1  sink accepts head byte.
- timer_irq  out  1  registered timer interrupt.

Behaviour:

Decode:
- addr[31]=0 selects RAM. Word index is addr[log2(RAM_WORDS)+1:2]. Upper bits alias; addr[1:0] are ignored. Accesses are full words only.
- addr[31]=1 selects MMIO, decoded on addr[4:2] (other bits ignored):
  - 0 CYCLE: read-only.
  - 1 TXDATA: write-only; reads return 0.
  - 2 STATUS: read-only.
  - 3 DROPCNT: read returns count; any write clears it.
  - 4 TIMECMP: read/write.
  - 5–7: read 0; writes ignored.

Reads and writes:
- readdata is purely combinational. It shows pre-edge state: a write and a read of the same location in one cycle returns the old value.
- A RAM write commits at the clock edge when memwrite=1. Write-then-read on consecutive cycles returns the new value.

Reset values:
- CYCLE=0, TIMECMP=0xFFFF_FFFF, DROPCNT=0, FIFO empty.
- tx_valid=0, tx_data=0, timer_irq=0.
- RAM contents are not reset.
- Reset applied mid-operation discards FIFO contents and any same-cycle write.

CYCLE:
- Increments by 1 every non-reset cycle and wraps from 0xFFFF_FFFF to 0.
- The first cycle after reset deasserts reads 0.
- Writes to CYCLE are ignored.

STATUS:
- bit0 = full, bit1 = empty, bits[12:8] = occupancy count (0..FIFO_DEPTH); other bits 0.

TX FIFO:
- A write to TXDATA pushes writedata[7:0].
- tx_valid = !empty; tx_data = head byte (0 when empty).
- A pop occurs on tx_valid & tx_ready.
- Push and pop in the same cycle:
  - Both take effect and occupancy is unchanged.
  - When full, this push is accepted because the pop frees a slot.
  - When empty, only the push occurs, since tx_valid=0.
- Push while full without a pop: the byte is dropped and DROPCNT increments. DROPCNT is 16-bit, saturates at 0xFFFF, and reads zero-extended.
- A clearing write to DROPCNT in the same cycle as a drop leaves DROPCNT=0 (clear wins).
- Read/write pointers wrap modulo FIFO_DEPTH.

Timer:
- timer_irq is registered: next value = (CYCLE >= TIMECMP), unsigned, evaluated on pre-edge values.
- Writing TIMECMP updates it at the edge. timer_irq reflects the new compare one cycle later.

Test Plan:
- Reset, then write 0xDEADBEEF to 0x0000_0010; read 0x0000_0010 next cycle -> 0xDEADBEEF. Read 0x0000_0110 (alias with RAM_WORDS=64) -> 0xDEADBEEF. Same-cycle read during the write -> old value.
- Release reset, read 0x8000_0000 on the first cycle -> 0, and 5 cycles later -> 5. Force wrap by running from a preloaded 0xFFFF_FFFF (via a long run or a bench-side force) -> next read 0.
- tx_ready=0; write 0x41..0x49 (9 bytes) to 0x8000_0004 -> STATUS=0x0000_0801 (count 8, full), DROPCNT=1. Then tx_ready=1 -> tx_data sequence 0x41..0x48, after which tx_valid=0 and STATUS=0x0000_0002.
- With the FIFO full, push 0x55 and hold tx_ready=1 in the same cycle -> count stays 8, DROPCNT unchanged, 0x55 emerges last.
- Write TIMECMP=20 at cycle 10 -> timer_irq=0 until CYCLE reaches 20, then rises one cycle later. Write TIMECMP=0xFFFF_FFFF -> timer_irq drops one cycle after the write.
- Push 3 bytes, then assert reset mid-drain -> tx_valid=0, STATUS=0x0000_0002, DROPCNT=0 the next cycle.
